// File: rtl/data_mem_if.sv
// Load/store request and response bundle between the LSU issue side and the
// MEM-stage data-memory responder.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_pc;
    logic        flush;
    logic        mem_vaild;
    logic [31:0] lwData_from_MEM;
    logic [31:0] pc_from_MEM;
    logic        st_done;
    logic        misalign_err;

    modport master (
        output req_valid, req_is_store, req_addr, req_wdata, req_size,
               req_unsigned, req_pc, flush,
        input  req_ready, mem_vaild, lwData_from_MEM, pc_from_MEM,
               st_done, misalign_err
    );

    modport slave (
        input  req_valid, req_is_store, req_addr, req_wdata, req_size,
               req_unsigned, req_pc, flush,
        output req_ready, mem_vaild, lwData_from_MEM, pc_from_MEM,
               st_done, misalign_err
    );
endinterface

// File: rtl/data_mem_stage.sv
// MEM-stage data-memory responder: one load/store at a time on an internal
// word-addressed RAM, with a fixed latency from acceptance to response pulse.
module data_mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LAT     = 2
) (
    input  logic       clk,
    input  logic       rstn,
    data_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [3:0]      cnt_r, cnt_nx_s;
    logic            ready_s, accept_s, fire_s;

    logic            lat_store_r, lat_unsigned_r;
    logic [AW+1:0]   lat_addr_r;
    logic [31:0]     lat_wdata_r, lat_pc_r;
    logic [1:0]      lat_size_r;

    logic            op_store_s, op_unsigned_s;
    logic [AW+1:0]   op_addr_s;
    logic [31:0]     op_wdata_s, op_pc_s;
    logic [1:0]      op_size_s;

    logic            misalign_s, do_write_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     rd_word_s, load_data_s, wlane_s;
    logic [3:0]      wmask_s;

    logic            mem_vaild_r, st_done_r, misalign_r;
    logic [31:0]     lwdata_r, pc_out_r;
    logic [31:0]     mem_r [DEPTH_WORDS];
    logic            unused_s;

    // Pick the requested lane out of a RAM word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  boff,
                                                input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {boff, 3'b000};
        case (size)
            2'b00:   res = {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Byte-enable mask for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                             input logic [1:0] boff);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << boff;
            2'b01:   m = 4'b0011 << {boff[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the store data's low lanes across the word so the mask picks the right bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] wd);
        logic [31:0] l;
        case (size)
            2'b00:   l = {4{wd[7:0]}};
            2'b01:   l = {2{wd[15:0]}};
            default: l = wd;
        endcase
        return l;
    endfunction

    assign ready_s  = (state_r == ST_IDLE) && !bus.flush;
    assign accept_s = bus.req_valid && ready_s;
    assign unused_s = ^bus.req_addr[31:AW+2];

    // In IDLE the access works straight off the request (needed when MEM_LAT is 1); otherwise off the latched copy.
    always_comb begin
        op_store_s    = lat_store_r;
        op_unsigned_s = lat_unsigned_r;
        op_addr_s     = lat_addr_r;
        op_wdata_s    = lat_wdata_r;
        op_size_s     = lat_size_r;
        op_pc_s       = lat_pc_r;
        if (state_r == ST_IDLE) begin
            op_store_s    = bus.req_is_store;
            op_unsigned_s = bus.req_unsigned;
            op_addr_s     = bus.req_addr[AW+1:0];
            op_wdata_s    = bus.req_wdata;
            op_size_s     = bus.req_size;
            op_pc_s       = bus.req_pc;
        end else begin
            op_store_s    = lat_store_r;
        end
    end

    // Address decode, alignment check and data path for the operation in hand.
    always_comb begin
        misalign_s  = ((op_size_s == 2'b01) && op_addr_s[0]) ||
                      (op_size_s[1] && (op_addr_s[1:0] != 2'b00));
        idx_s       = op_addr_s[AW+1:2];
        rd_word_s   = mem_r[idx_s];
        load_data_s = load_extend(rd_word_s, op_size_s, op_addr_s[1:0], op_unsigned_s);
        wmask_s     = byte_mask(op_size_s, op_addr_s[1:0]);
        wlane_s     = store_lanes(op_size_s, op_wdata_s);
        do_write_s  = rstn && fire_s && op_store_s && !misalign_s;
    end

    // Next-state logic; fire_s marks the edge that enters RESP.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        fire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (MEM_LAT == 1) begin
                        state_nx_s = ST_RESP;
                        fire_s     = 1'b1;
                    end else begin
                        state_nx_s = ST_BUSY;
                        cnt_nx_s   = 4'(MEM_LAT - 1);
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 4'd0;
                end else if (cnt_r == 4'd1) begin
                    state_nx_s = ST_RESP;
                    cnt_nx_s   = 4'd0;
                    fire_s     = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_store_r    <= 1'b0;
            lat_unsigned_r <= 1'b0;
            lat_addr_r     <= '0;
            lat_wdata_r    <= 32'd0;
            lat_size_r     <= 2'd0;
            lat_pc_r       <= 32'd0;
        end else if (accept_s) begin
            lat_store_r    <= bus.req_is_store;
            lat_unsigned_r <= bus.req_unsigned;
            lat_addr_r     <= bus.req_addr[AW+1:0];
            lat_wdata_r    <= bus.req_wdata;
            lat_size_r     <= bus.req_size;
            lat_pc_r       <= bus.req_pc;
        end
    end

    // Response pulses and held load data / PC, all set on the RESP entry edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_vaild_r <= 1'b0;
            st_done_r   <= 1'b0;
            misalign_r  <= 1'b0;
            lwdata_r    <= 32'd0;
            pc_out_r    <= 32'd0;
        end else begin
            mem_vaild_r <= fire_s && !op_store_s && !misalign_s;
            st_done_r   <= fire_s && op_store_s && !misalign_s;
            misalign_r  <= fire_s && misalign_s;
            if (fire_s) begin
                pc_out_r <= op_pc_s;
            end
            if (fire_s && !op_store_s && !misalign_s) begin
                lwdata_r <= load_data_s;
            end
        end
    end

    // RAM array: byte-lane writes, no reset on the contents.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready       = ready_s;
    assign bus.mem_vaild       = mem_vaild_r;
    assign bus.st_done         = st_done_r;
    assign bus.misalign_err    = misalign_r;
    assign bus.lwData_from_MEM = lwdata_r;
    assign bus.pc_from_MEM     = pc_out_r;
endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed cases plus random traffic
// against a byte-addressed memory model; a second instance with MEM_LAT=1
// covers back-to-back throughput and address aliasing.
module tb_data_mem_stage;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    data_mem_if bus ();
    data_mem_if bus1 ();

    data_mem_stage #(.DEPTH_WORDS(256), .MEM_LAT(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    data_mem_stage #(.DEPTH_WORDS(256), .MEM_LAT(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mb [1024];
    logic [31:0] exp_lw;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference: 1024 bytes, little-endian, address taken modulo the RAM size.
    task automatic model(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input bit uns,
                         output bit mis, output logic [31:0] ld);
        int     n;
        int     base;
        longint v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis  = (addr % 32'(n)) != 32'd0;
        base = int'(addr % 32'd1024);
        ld   = 32'd0;
        if (!mis) begin
            if (st) begin
                for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(mb[base + i]) << (8 * i);
                if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
                ld = v[31:0];
            end
        end
    endtask

    function automatic logic [2:0] pulses();
        return {bus.mem_vaild, bus.st_done, bus.misalign_err};
    endfunction

    task automatic issue(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input bit uns, input logic [31:0] pc);
        int waited;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_pc       = pc;
        #1;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) chk("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    task automatic op(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input bit uns, input logic [31:0] pc);
        bit          mis;
        logic [31:0] ld;
        int          lat;
        model(st, addr, wd, sz, uns, mis, ld);
        issue(st, addr, wd, sz, uns, pc);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (pulses() != 3'b000) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd2);
        chk("mem_vaild", 32'(bus.mem_vaild), 32'(!st && !mis));
        chk("st_done", 32'(bus.st_done), 32'(st && !mis));
        chk("misalign_err", 32'(bus.misalign_err), 32'(mis));
        if (!st && !mis) exp_lw = ld;
        exp_pc = pc;
        chk("lwData", bus.lwData_from_MEM, exp_lw);
        chk("pc_from_MEM", bus.pc_from_MEM, exp_pc);
        chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("pulse_width", 32'(pulses()), 32'd0);
        chk("ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_lw = 32'd0;
        exp_pc = 32'd0;
        for (int i = 0; i < 1024; i++) mb[i] = 8'd0;
        rstn = 1'b0;
        bus.req_valid = 1'b0;  bus.req_is_store = 1'b0; bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_size = 2'd0;     bus.req_unsigned = 1'b0;
        bus.req_pc = 32'd0;    bus.flush = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_is_store = 1'b0; bus1.req_addr = 32'd0;
        bus1.req_wdata = 32'd0; bus1.req_size = 2'd0;    bus1.req_unsigned = 1'b0;
        bus1.req_pc = 32'd0;   bus1.flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pulses", 32'(pulses()), 32'd0);
        chk("rst_lw", bus.lwData_from_MEM, 32'd0);
        chk("rst_pc", bus.pc_from_MEM, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);

        // Fill every RAM word so the model and the array agree from here on.
        for (int w = 0; w < 256; w++) op(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 32'h1000 + 32'(w));

        // Test 1: word store then load
        op(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h2000);
        op(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 32'h2004);
        chk("t1_lw", bus.lwData_from_MEM, 32'hDEADBEEF);
        chk("t1_pc", bus.pc_from_MEM, 32'h2004);
        // Test 2: byte/half extension
        op(1'b0, 32'h13, 32'd0, 2'd0, 1'b0, 32'h2008);
        chk("t2_byte_s", bus.lwData_from_MEM, 32'hFFFFFFDE);
        op(1'b0, 32'h13, 32'd0, 2'd0, 1'b1, 32'h200C);
        chk("t2_byte_u", bus.lwData_from_MEM, 32'h000000DE);
        op(1'b0, 32'h12, 32'd0, 2'd1, 1'b0, 32'h2010);
        chk("t2_half_s", bus.lwData_from_MEM, 32'hFFFFDEAD);
        // Test 3: sub-word stores
        op(1'b1, 32'h11, 32'hAAAAAA55, 2'd0, 1'b0, 32'h2014);
        op(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 32'h2018);
        chk("t3_byte_st", bus.lwData_from_MEM, 32'hDEAD55EF);
        op(1'b1, 32'h12, 32'hBBBB1234, 2'd1, 1'b0, 32'h201C);
        op(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 32'h2020);
        chk("t3_half_st", bus.lwData_from_MEM, 32'h123455EF);
        // Test 4: misaligned word load
        op(1'b0, 32'h12, 32'd0, 2'd2, 1'b0, 32'h2024);
        chk("t4_lw_hold", bus.lwData_from_MEM, 32'h123455EF);
        chk("t4_pc", bus.pc_from_MEM, 32'h2024);

        // Test 5: store flushed while in flight
        issue(1'b1, 32'h20, 32'h0BADF00D, 2'd2, 1'b0, 32'h3000);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("t5_ready_flush", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_pulse", 32'(pulses()), 32'd0);
            chk("t5_idle", 32'(bus.req_ready), 32'd1);
        end
        chk("t5_lw_hold", bus.lwData_from_MEM, exp_lw);
        chk("t5_pc_hold", bus.pc_from_MEM, exp_pc);
        op(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 32'h3004);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_addr = 32'h24;
        bus.req_size = 2'd2; bus.flush = 1'b1;
        #1;
        chk("idle_flush_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_flush_no_pulse", 32'(pulses()), 32'd0);
        end

        // Randomized traffic with aliasing addresses and all sizes
        for (int n = 0; n < 80; n++) begin
            op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), $urandom,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Async reset while a store is in BUSY: outputs clear, store is dropped
        issue(1'b1, 32'h30, 32'h77778888, 2'd2, 1'b0, 32'h4000);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_busy_pulses", 32'(pulses()), 32'd0);
        chk("rst_busy_lw", bus.lwData_from_MEM, 32'd0);
        chk("rst_busy_pc", bus.pc_from_MEM, 32'd0);
        exp_lw = 32'd0;
        exp_pc = 32'd0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_busy_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy_no_pulse", 32'(pulses()), 32'd0);
        op(1'b0, 32'h30, 32'd0, 2'd2, 1'b0, 32'h4004);

        // MEM_LAT=1 instance: back-to-back acceptance every second cycle, 0x400 aliases 0x0
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_is_store = 1'b1; bus1.req_addr = 32'h0;
        bus1.req_wdata = 32'hCAFEF00D; bus1.req_size = 2'd2; bus1.req_pc = 32'h5000;
        #1;
        chk("l1_ready0", 32'(bus1.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus1.req_is_store = 1'b0; bus1.req_addr = 32'h400; bus1.req_pc = 32'h5004;
        @(negedge clk);
        chk("l1_st_done", 32'(bus1.st_done), 32'd1);
        chk("l1_ready_resp", 32'(bus1.req_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("l1_ready_alt", 32'(bus1.req_ready), 32'(i % 2 == 0));
            chk("l1_vaild_alt", 32'(bus1.mem_vaild), 32'(i % 2 == 1));
        end
        chk("l1_alias_lw", bus1.lwData_from_MEM, 32'hCAFEF00D);
        chk("l1_pc", bus1.pc_from_MEM, 32'h5004);
        bus1.req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
